clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_ch.sv | 102 ++++++++++
 rtl/clk_div_multi.sv | 54 +++++
 tb/tb_clk_div_multi.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the multi-channel clock divider:
//   DEF_NUM_CH  - default number of divided-clock channels
//   DEF_CNT_W   - default width of a half-period divider value
//   MAX_CH      - largest channel count addressable by the 3-bit write index
//   reset_ratio - reset half-period of channel i (2^i)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_CNT_W  = 8;
    localparam int MAX_CH     = 8;

    // Channel i comes out of reset dividing by 2*2^i (clk/2, clk/4, clk/8, ...).
    function automatic logic [31:0] reset_ratio(input int unsigned ch);
        return 32'd1 << ch;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One divided-clock channel: shadow divider, active divider, half-period
// counter, registered output clock and rising-edge tick.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-low
//   enb     in   count enable; 0 freezes counter/output and forces tick=0
//   resync  in   restart the channel phase and reload the active divider
//   wr      in   load wr_div into the shadow divider
//   wr_div  in   new half-period value
//   clk_out out  divided clock (high phase first, 50% duty)
//   tick    out  1 in the first high cycle of each clk_out period
//
// A period is high phase then low phase. The period boundary is the terminal
// count that ends the low phase; that is the only point where the shadow
// value moves into the active divider, so a new ratio never cuts or stretches
// a half-period in progress. After reset or resync the first enabled cycle
// raises clk_out immediately, so every channel's first rising edge lands on
// the same cycle and ratios k and 2k keep sharing rising edges.
// -----------------------------------------------------------------------------
module clk_div_ch #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             resync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] div_sh;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] cnt;
    logic             start;     // phase restart pending: rise on next enabled cycle

    logic terminal;
    logic rise;
    logic fall;

    assign terminal = (cnt == div_act - CNT_W'(1));
    assign rise     = start || (!clk_out && terminal);
    assign fall     = clk_out && terminal;

    // NOTE: every state register gets a reset value here, including both
    // divider copies, so the channel ratio is defined from the first cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_sh  <= RST_DIV;
            div_act <= RST_DIV;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            start   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below sees the pre-edge div_sh; a write landing on a boundary
            // therefore only takes effect at the following boundary.
            if (wr) begin
                div_sh <= wr_div;
            end
            tick <= 1'b0;

            if (resync) begin
                // A same-cycle write is folded straight into the transfer.
                div_act <= wr ? wr_div : div_sh;
                cnt     <= '0;
                clk_out <= 1'b0;
                start   <= 1'b1;
            end else if (enb) begin
                if (div_act == '0) begin
                    // Idle: keep polling the shadow for a nonzero ratio.
                    div_act <= div_sh;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    start   <= 1'b0;
                end else if (rise) begin
                    // Period boundary: adopt the shadow ratio. A zero ratio
                    // parks the channel low instead of emitting a stub pulse.
                    div_act <= div_sh;
                    cnt     <= '0;
                    start   <= 1'b0;
                    if (div_sh != '0) begin
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                    end
                end else if (fall) begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent 50%-duty clock dividers sharing one write port.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-low
//   enb      in   global count enable
//   resync   in   one-cycle request to phase-align all channels
//   wr_en    in   divider write strobe
//   wr_ch    in   target channel of the write (indices >= NUM_CH ignored)
//   wr_div   in   new half-period value
//   clk_out  out  divided clock per channel
//   tick     out  one-cycle pulse per channel at each clk_out rise
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              resync,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Only existing channels decode, so out-of-range indices fall away.
        assign wr_sel[i] = wr_en && (wr_ch == 3'(i));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .RST_DIV (CNT_W'(reset_ratio(i)))
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enb     (enb),
            .resync  (resync),
            .wr      (wr_sel[i]),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi with default parameters (3 channels).
// Inputs change 1 ns after a rising edge; outputs are read at the same point,
// so each observation reflects the most recent edge. Traces are captured
// first-cycle-in-MSB and compared with hand-derived bit patterns.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              enb;
    logic              resync;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    logic [31:0] tr_clk  [NUM_CH];
    logic [31:0] tr_tick [NUM_CH];

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .resync  (resync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        resync = 1'b0;
        wr_en  = 1'b0;
        enb    = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic write(input logic [2:0] ch, input logic [CNT_W-1:0] div);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = div;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic run_trace(input int n);
        for (int c = 0; c < NUM_CH; c++) begin
            tr_clk[c]  = '0;
            tr_tick[c] = '0;
        end
        repeat (n) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                tr_clk[c]  = {tr_clk[c][30:0], clk_out[c]};
                tr_tick[c] = {tr_tick[c][30:0], tick[c]};
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (clk_out !== 3'b000) begin
            errors++;
            $display("FAIL reset_clk_out got %b exp 000", clk_out);
        end
        checks++;
        if (tick !== 3'b000) begin
            errors++;
            $display("FAIL reset_tick got %b exp 000", tick);
        end
    endtask

    task automatic test_defaults();
        do_reset();
        run_trace(16);
        checks++;
        if (tr_clk[0] !== 32'h0000_AAAA) begin
            errors++; $display("FAIL dflt_clk0 got %h exp 0000aaaa", tr_clk[0]);
        end
        checks++;
        if (tr_clk[1] !== 32'h0000_CCCC) begin
            errors++; $display("FAIL dflt_clk1 got %h exp 0000cccc", tr_clk[1]);
        end
        checks++;
        if (tr_clk[2] !== 32'h0000_F0F0) begin
            errors++; $display("FAIL dflt_clk2 got %h exp 0000f0f0", tr_clk[2]);
        end
        checks++;
        if (tr_tick[0] !== 32'h0000_AAAA) begin
            errors++; $display("FAIL dflt_tick0 got %h exp 0000aaaa", tr_tick[0]);
        end
        checks++;
        if (tr_tick[1] !== 32'h0000_8888) begin
            errors++; $display("FAIL dflt_tick1 got %h exp 00008888", tr_tick[1]);
        end
        checks++;
        if (tr_tick[2] !== 32'h0000_8080) begin
            errors++; $display("FAIL dflt_tick2 got %h exp 00008080", tr_tick[2]);
        end
    endtask

    task automatic test_write_mid_high();
        logic [31:0] exp_clk1;
        logic [31:0] exp_tick1;
        exp_clk1  = 32'b00_111000_111000_111000_111000_111000;
        exp_tick1 = 32'b00_100000_100000_100000_100000_100000;
        do_reset();
        repeat (17) step();            // ch1 just rose at E17
        write(3'd1, 8'd3);             // lands at E18, second high cycle
        run_trace(32);                 // E19..E50
        checks++;
        if (tr_clk[1] !== exp_clk1) begin
            errors++; $display("FAIL wr_clk1 got %b exp %b", tr_clk[1], exp_clk1);
        end
        checks++;
        if (tr_tick[1] !== exp_tick1) begin
            errors++; $display("FAIL wr_tick1 got %b exp %b", tr_tick[1], exp_tick1);
        end
        checks++;
        if (tr_clk[0] !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL wr_clk0 got %h exp aaaaaaaa", tr_clk[0]);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        repeat (6) step();             // ch1 mid-high, ch2 mid-low
        enb = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            checks++;
            if (clk_out !== 3'b010 || tick !== 3'b000) begin
                errors++;
                $display("FAIL freeze_hold cyc %0d got clk %b tick %b exp clk 010 tick 000",
                         k, clk_out, tick);
            end
        end
        enb = 1'b1;
        run_trace(16);
        checks++;
        if (tr_clk[0] !== 32'h0000_AAAA) begin
            errors++; $display("FAIL resume_clk0 got %h exp 0000aaaa", tr_clk[0]);
        end
        checks++;
        if (tr_clk[1] !== 32'h0000_3333) begin
            errors++; $display("FAIL resume_clk1 got %h exp 00003333", tr_clk[1]);
        end
        checks++;
        if (tr_clk[2] !== 32'h0000_3C3C) begin
            errors++; $display("FAIL resume_clk2 got %h exp 00003c3c", tr_clk[2]);
        end
        checks++;
        if (tr_tick[2] !== 32'h0000_2020) begin
            errors++; $display("FAIL resume_tick2 got %h exp 00002020", tr_tick[2]);
        end
    endtask

    task automatic test_idle_restart();
        logic [31:0] exp_clk2;
        logic [31:0] exp_tick2;
        exp_clk2  = 32'b00000_11111_00000_11111_00000_11111_00;
        exp_tick2 = 32'b00000_10000_00000_10000_00000_10000_00;
        do_reset();
        repeat (2) step();
        write(3'd2, 8'd0);
        run_trace(32);                 // E4..E35: finish high, low, then park
        checks++;
        if (tr_clk[2] !== 32'h8000_0000) begin
            errors++; $display("FAIL idle_clk2 got %h exp 80000000", tr_clk[2]);
        end
        checks++;
        if (tr_tick[2] !== 32'h0000_0000) begin
            errors++; $display("FAIL idle_tick2 got %h exp 00000000", tr_tick[2]);
        end
        write(3'd2, 8'd5);
        run_trace(32);                 // load cycle, 5 low, then period 10
        checks++;
        if (tr_clk[2] !== exp_clk2) begin
            errors++; $display("FAIL restart_clk2 got %b exp %b", tr_clk[2], exp_clk2);
        end
        checks++;
        if (tr_tick[2] !== exp_tick2) begin
            errors++; $display("FAIL restart_tick2 got %b exp %b", tr_tick[2], exp_tick2);
        end
    endtask

    task automatic test_resync();
        logic [31:0] exp_c1;
        logic [31:0] exp_c2;
        logic [31:0] exp_t1;
        logic [31:0] exp_t2;
        exp_c1 = 32'b111000_111000_111000_111000;
        exp_c2 = 32'b11110000_11110000_11110000;
        exp_t1 = 32'b100000_100000_100000_100000;
        exp_t2 = 32'b10000000_10000000_10000000;
        do_reset();
        step();
        write(3'd1, 8'd3);
        repeat (4) step();
        resync = 1'b1;
        wr_en  = 1'b1;
        wr_ch  = 3'd5;
        wr_div = 8'd9;
        step();
        resync = 1'b0;
        wr_en  = 1'b0;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000) begin
            errors++;
            $display("FAIL resync_clear got clk %b tick %b exp 000/000", clk_out, tick);
        end
        run_trace(24);
        checks++;
        if (tr_clk[0] !== 32'h00AA_AAAA) begin
            errors++; $display("FAIL resync_clk0 got %h exp 00aaaaaa", tr_clk[0]);
        end
        checks++;
        if (tr_clk[1] !== exp_c1) begin
            errors++; $display("FAIL resync_clk1 got %b exp %b", tr_clk[1], exp_c1);
        end
        checks++;
        if (tr_clk[2] !== exp_c2) begin
            errors++; $display("FAIL resync_clk2 got %b exp %b", tr_clk[2], exp_c2);
        end
        checks++;
        if (tr_tick[0] !== 32'h00AA_AAAA) begin
            errors++; $display("FAIL resync_tick0 got %h exp 00aaaaaa", tr_tick[0]);
        end
        checks++;
        if (tr_tick[1] !== exp_t1) begin
            errors++; $display("FAIL resync_tick1 got %b exp %b", tr_tick[1], exp_t1);
        end
        checks++;
        if (tr_tick[2] !== exp_t2) begin
            errors++; $display("FAIL resync_tick2 got %b exp %b", tr_tick[2], exp_t2);
        end
    endtask

    task automatic test_reset_mid_run();
        write(3'd2, 8'd6);             // pending in shadow only
        rst    = 1'b0;
        wr_en  = 1'b1;
        wr_ch  = 3'd0;
        wr_div = 8'd7;
        resync = 1'b1;
        step();
        rst    = 1'b1;
        wr_en  = 1'b0;
        resync = 1'b0;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000) begin
            errors++;
            $display("FAIL midrst_clear got clk %b tick %b exp 000/000", clk_out, tick);
        end
        run_trace(16);
        checks++;
        if (tr_clk[0] !== 32'h0000_AAAA) begin
            errors++; $display("FAIL midrst_clk0 got %h exp 0000aaaa", tr_clk[0]);
        end
        checks++;
        if (tr_clk[1] !== 32'h0000_CCCC) begin
            errors++; $display("FAIL midrst_clk1 got %h exp 0000cccc", tr_clk[1]);
        end
        checks++;
        if (tr_clk[2] !== 32'h0000_F0F0) begin
            errors++; $display("FAIL midrst_clk2 got %h exp 0000f0f0", tr_clk[2]);
        end
    endtask

    initial begin
        rst    = 1'b0;
        enb    = 1'b1;
        resync = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 3'd0;
        wr_div = '0;

        test_reset();
        test_defaults();
        test_write_mid_high();
        test_freeze();
        test_idle_restart();
        test_resync();
        test_reset_mid_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
